// File: rtl/delta_forward.sv
// -----------------------------------------------------------------------------
// delta_forward
//   Encoder-side delta + bit-plane stage. Collects BLOCK_SIZE serial signed
//   words. Word 0 is kept as the block base. The remaining words are turned
//   into BLOCK_SIZE-1 successive differences, each DATA_W+1 bits wide, and the
//   differences are stored transposed as bit planes. One valid/ready handshake
//   hands over each block. delta_reverse on the decoder side is the exact
//   inverse of this stage.
//
// Ports
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   data_i   in   [DATA_W-1:0]  signed input word
//   vld_i    in   data_i valid
//   rdy_o    out  data_i accepted when vld_i && rdy_o (combinational)
//   flush_i  in   close a partial block; the missing diffs read as zero
//   base_o   out  [DATA_W-1:0]  block base (word 0)
//   dbp_o    out  [DATA_W:0][BLOCK_SIZE-2:0]
//                 dbp_o[j][BLOCK_SIZE-2-i] = bit j of diff i
//   vld_o    out  block valid
//   rdy_i    in   block consumed when vld_o && rdy_i
//   clr_i    in   synchronous clear; it has priority over everything else
// -----------------------------------------------------------------------------
module delta_forward #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [DATA_W-1:0]                   data_i,
  input  logic                                vld_i,
  output logic                                rdy_o,
  input  logic                                flush_i,
  output logic [DATA_W-1:0]                   base_o,
  output logic [DATA_W:0][BLOCK_SIZE-2:0]     dbp_o,
  output logic                                vld_o,
  input  logic                                rdy_i,
  input  logic                                clr_i
);

  localparam int               IDX_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_SIZE - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                           state_r;
  state_e                           state_nxt_s;
  logic [IDX_W-1:0]                 idx_r;
  logic [IDX_W-1:0]                 idx_nxt_s;
  logic [DATA_W-1:0]                prev_r;
  logic [DATA_W-1:0]                base_r;
  logic [DATA_W:0][BLOCK_SIZE-2:0]  dbp_r;
  logic [DATA_W:0][BLOCK_SIZE-2:0]  dbp_wr_s;
  logic [DATA_W:0]                  diff_s;
  logic                             rdy_s;
  logic                             vld_s;
  logic                             accept_s;

  // Sign-extend both operands by one bit so that the difference is always exact.
  function automatic logic [DATA_W:0] word_diff(input logic [DATA_W-1:0] cur,
                                                input logic [DATA_W-1:0] prv);
    word_diff = {cur[DATA_W-1], cur} - {prv[DATA_W-1], prv};
  endfunction

  // A word is taken only when the handshake holds and no clear is pending.
  assign accept_s = vld_i & rdy_s & ~clr_i;
  assign diff_s   = word_diff(data_i, prev_r);

  // FSM state register: the block phase and the word index inside the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_FILL;
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // FSM next-state logic: block close on the last word or on flush, release on handshake.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    if (clr_i) begin
      state_nxt_s = ST_FILL;
      idx_nxt_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            if (idx_r == IDX_LAST) begin
              // The last word and a flush in the same cycle close the block only once.
              state_nxt_s = ST_HOLD;
              idx_nxt_s   = IDX_ZERO;
            end else if (flush_i) begin
              // The index after this accept is non-zero, so the partial block closes.
              state_nxt_s = ST_HOLD;
              idx_nxt_s   = IDX_ZERO;
            end else begin
              state_nxt_s = ST_FILL;
              idx_nxt_s   = idx_r + IDX_ONE;
            end
          end else begin
            if (flush_i && (idx_r != IDX_ZERO)) begin
              state_nxt_s = ST_HOLD;
              idx_nxt_s   = IDX_ZERO;
            end else begin
              state_nxt_s = ST_FILL;
              idx_nxt_s   = idx_r;
            end
          end
        end
        ST_HOLD: begin
          if (rdy_i) begin
            // A word accepted during the handshake becomes word 0 of the next block.
            state_nxt_s = ST_FILL;
            idx_nxt_s   = accept_s ? IDX_ONE : IDX_ZERO;
          end else begin
            state_nxt_s = ST_HOLD;
            idx_nxt_s   = IDX_ZERO;
          end
        end
        default: begin
          state_nxt_s = ST_FILL;
          idx_nxt_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // FSM output decode: in HOLD, acceptance passes through from the downstream ready.
  always_comb begin
    rdy_s = 1'b0;
    vld_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        rdy_s = 1'b1;
        vld_s = 1'b0;
      end
      ST_HOLD: begin
        rdy_s = rdy_i;
        vld_s = 1'b1;
      end
      default: begin
        rdy_s = 1'b0;
        vld_s = 1'b0;
      end
    endcase
  end

  // Column insert: the diff produced at index k lands in column BLOCK_SIZE-1-k of every plane.
  always_comb begin
    dbp_wr_s = dbp_r;
    for (int c = 0; c < BLOCK_SIZE - 1; c++) begin
      if (idx_r == IDX_W'(BLOCK_SIZE - 1 - c)) begin
        for (int j = 0; j <= DATA_W; j++) begin
          dbp_wr_s[j][c] = diff_s[j];
        end
      end else begin
        for (int j = 0; j <= DATA_W; j++) begin
          dbp_wr_s[j][c] = dbp_r[j][c];
        end
      end
    end
  end

  // Datapath registers: base, last accepted word and the bit-plane array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_r <= {DATA_W{1'b0}};
      prev_r <= {DATA_W{1'b0}};
      dbp_r  <= '0;
    end else if (clr_i) begin
      base_r <= {DATA_W{1'b0}};
      prev_r <= {DATA_W{1'b0}};
      dbp_r  <= '0;
    end else if (accept_s) begin
      prev_r <= data_i;
      if (idx_r == IDX_ZERO) begin
        // A new block starts. Clearing the planes makes unwritten diffs read as zero.
        base_r <= data_i;
        dbp_r  <= '0;
      end else begin
        base_r <= base_r;
        dbp_r  <= dbp_wr_s;
      end
    end else begin
      base_r <= base_r;
      prev_r <= prev_r;
      dbp_r  <= dbp_r;
    end
  end

  assign rdy_o  = rdy_s;
  assign vld_o  = vld_s;
  assign base_o = base_r;
  assign dbp_o  = dbp_r;

endmodule
